// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 stream feeder: FSM encoding, widths and
// padding constants.
package sha256_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_PAD,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    localparam int           SHA_BLOCK_W  = 512;
    localparam int           SHA_DIGEST_W = 256;
    localparam logic [7:0]   PAD_BYTE     = 8'h80;

    // Out-of-range byte counts on the last beat mean a full word.
    function automatic logic [2:0] norm_last_bytes(input logic [2:0] lb);
        return (lb == 3'd0 || lb > 3'd4) ? 3'd4 : lb;
    endfunction
endpackage

// File: rtl/sha256_pad_word.sv
// Final-word shaping: keeps the valid MSB-aligned bytes, zeroes the rest and
// drops the 0x80 pad marker right after the last valid byte.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  last_bytes,
    output logic [31:0] word
);
    always_comb begin
        word = data;
        case (last_bytes)
            3'd1:    word = {data[31:24], PAD_BYTE, 16'h0000};
            3'd2:    word = {data[31:16], PAD_BYTE, 8'h00};
            3'd3:    word = {data[31:8],  PAD_BYTE};
            default: word = data;
        endcase
    end
endmodule

// File: rtl/sha256_stream_feeder.sv
// Packs a big-endian word stream into padded 512-bit SHA-256 blocks and drives
// the core's init/next handshake one block at a time, capturing the digest.
module sha256_stream_feeder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [31:0]             s_data,
    input  logic                    s_last,
    input  logic [2:0]              s_last_bytes,
    output logic                    busy,
    output logic [SHA_DIGEST_W-1:0] digest,
    output logic                    digest_valid,
    output logic                    core_init,
    output logic                    core_next,
    output logic                    core_mode,
    output logic [SHA_BLOCK_W-1:0]  core_block,
    input  logic                    core_ready,
    input  logic [SHA_DIGEST_W-1:0] core_digest,
    input  logic                    core_digest_valid
);
    localparam int CNT_W = LEN_W - 3;

    state_t           state;
    logic [0:15][31:0] blk;
    logic [3:0]       w;
    logic [4:0]       p;
    logic [CNT_W-1:0] byte_cnt;
    logic             first_blk, final_blk, need_len, pad_lead, wait_first;

    logic             beat;
    logic [3:0]       wi;
    logic [2:0]       lb;
    logic [31:0]      last_word;
    logic [CNT_W-1:0] cnt_base;
    logic [63:0]      len_field;

    assign beat       = s_valid & s_ready;
    assign wi         = (state == ST_IDLE) ? 4'd0 : w;
    assign lb         = norm_last_bytes(s_last_bytes);
    assign cnt_base   = (state == ST_IDLE) ? '0 : byte_cnt;
    assign len_field  = 64'({byte_cnt, 3'b000});
    assign core_mode  = 1'b1;
    assign core_block = blk;

    sha256_pad_word u_pad (
        .data       (s_data),
        .last_bytes (lb),
        .word       (last_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            blk          <= '0;
            w            <= '0;
            p            <= '0;
            byte_cnt     <= '0;
            first_blk    <= 1'b0;
            final_blk    <= 1'b0;
            need_len     <= 1'b0;
            pad_lead     <= 1'b0;
            wait_first   <= 1'b0;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            core_init    <= 1'b0;
            core_next    <= 1'b0;
        end else begin
            core_init    <= 1'b0;
            core_next    <= 1'b0;
            digest_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    s_ready <= 1'b1;
                    if (beat) begin
                        if (state == ST_IDLE) begin
                            first_blk <= 1'b1;
                            busy      <= 1'b1;
                            final_blk <= 1'b0;
                            need_len  <= 1'b0;
                            pad_lead  <= 1'b0;
                        end
                        if (!s_last) begin
                            blk[wi]  <= s_data;
                            byte_cnt <= cnt_base + CNT_W'(4);
                            if (wi == 4'd15) begin
                                state   <= ST_ISSUE;
                                s_ready <= 1'b0;
                            end else begin
                                w     <= wi + 4'd1;
                                state <= ST_COLLECT;
                            end
                        end else begin
                            blk[wi]  <= last_word;
                            byte_cnt <= cnt_base + CNT_W'(lb);
                            if (lb == 3'd4) begin
                                // A message ending on a block boundary carries its
                                // 0x80 marker into the length-only block.
                                if (wi != 4'd15)
                                    blk[wi + 4'd1] <= {PAD_BYTE, 24'h0};
                                pad_lead <= (wi == 4'd15);
                                p        <= {1'b0, wi} + 5'd2;
                            end else begin
                                p <= {1'b0, wi} + 5'd1;
                            end
                            state   <= ST_PAD;
                            s_ready <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    for (int i = 0; i < 16; i++)
                        if (5'(i) >= p) blk[i] <= '0;
                    if (p <= 5'd14) begin
                        blk[14]   <= len_field[63:32];
                        blk[15]   <= len_field[31:0];
                        final_blk <= 1'b1;
                    end else begin
                        final_blk <= 1'b0;
                        need_len  <= 1'b1;
                    end
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (core_ready) begin
                        if (first_blk) core_init <= 1'b1;
                        else           core_next <= 1'b1;
                        first_blk  <= 1'b0;
                        wait_first <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // core_ready still shows the pre-pulse idle level for one cycle
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (core_ready) begin
                        if (need_len) begin
                            blk       <= '0;
                            blk[0]    <= pad_lead ? {PAD_BYTE, 24'h0} : 32'h0;
                            blk[14]   <= len_field[63:32];
                            blk[15]   <= len_field[31:0];
                            final_blk <= 1'b1;
                            need_len  <= 1'b0;
                            state     <= ST_ISSUE;
                        end else if (final_blk) begin
                            if (core_digest_valid) begin
                                digest       <= core_digest;
                                digest_valid <= 1'b1;
                                busy         <= 1'b0;
                                s_ready      <= 1'b1;
                                state        <= ST_IDLE;
                            end
                        end else begin
                            w       <= '0;
                            s_ready <= 1'b1;
                            state   <= ST_COLLECT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
